lw_hmac_seq: RTL and testbench

- Parametrised HMAC sequencer wrapping an external streaming SHA-2 core; next generation of the lightweight HMAC wrapper.
- Generalised in word width, block size and digest size.
- Adds variable-length key load with zero fill, key retention across messages, plain-SHA bypass, error reporting and an explicit core-side handshake.
- Sits between the bus/DMA front end and the lw SHA core.

---
 rtl/lw_hmac_seq.sv | 193 +++++++++++++++++++
 tb/tb_lw_hmac_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_hmac_seq.sv
// rtl/lw_hmac_seq.sv - HMAC / plain-SHA sequencer around an external streaming SHA-2 core
module lw_hmac_seq #(
  parameter int WORD_W       = 32,
  parameter int BLOCK_WORDS  = 16,
  parameter int DIGEST_WORDS = 8,
  parameter int KCNT_W       = $clog2(BLOCK_WORDS + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           mode_i,
  input  logic                           reuse_key_i,
  input  logic [KCNT_W-1:0]              key_words_i,
  input  logic [WORD_W-1:0]              key_i,
  input  logic                           key_valid_i,
  output logic                           key_ready_o,
  input  logic [WORD_W-1:0]              data_i,
  input  logic                           data_valid_i,
  input  logic                           data_last_i,
  output logic                           data_ready_o,
  input  logic                           abort_i,
  output logic                           core_start_o,
  output logic [WORD_W-1:0]              core_data_o,
  output logic                           core_valid_o,
  output logic                           core_last_o,
  input  logic                           core_ready_i,
  output logic                           core_abort_o,
  input  logic                           core_done_i,
  input  logic [DIGEST_WORDS*WORD_W-1:0] core_digest_i,
  output logic [DIGEST_WORDS*WORD_W-1:0] hash_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic                           key_loaded_o,
  output logic                           err_o
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int DIG_W = DIGEST_WORDS * WORD_W;
  localparam logic [WORD_W-1:0] IPAD     = {(WORD_W/8){8'h36}};
  localparam logic [WORD_W-1:0] OPAD     = {(WORD_W/8){8'h5c}};
  localparam logic [CNT_W-1:0]  BLK_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  DIG_LAST = CNT_W'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY_LOAD, ST_IKEY, ST_MSG, ST_WAIT_I, ST_OKEY, ST_ODIG, ST_WAIT_O
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q;
  logic [KCNT_W-1:0]   key_len_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic                entry_q;
  logic [WORD_W-1:0]   key_q [BLOCK_WORDS];
  logic [DIG_W-1:0]    dig_q;
  logic [DIG_W-1:0]    hash_q;
  logic                key_loaded_q;
  logic                done_q;
  logic                err_q;

  logic                key_len_ok;
  logic                start_err;
  logic                adv;
  logic                aborting;
  logic                key_acc;
  logic [WORD_W-1:0]   pad_word;

  assign key_len_ok = (key_words_i != '0) && (key_words_i <= KCNT_W'(BLOCK_WORDS));
  assign aborting   = abort_i && (state_q != ST_IDLE);
  assign key_acc    = (state_q == ST_KEY_LOAD) && key_valid_i && !abort_i;

  always_comb begin
    state_d      = state_q;
    start_err    = 1'b0;
    adv          = 1'b0;
    key_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    core_last_o  = 1'b0;
    core_start_o = 1'b0;
    core_abort_o = aborting;
    pad_word     = key_q[wcnt_q] ^ ((state_q == ST_OKEY) ? OPAD : IPAD);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (!mode_i)          state_d = ST_MSG;
          else if (reuse_key_i) begin
            if (key_loaded_q)   state_d = ST_IKEY;
            else                start_err = 1'b1;
          end
          else if (key_len_ok)  state_d = ST_KEY_LOAD;
          else                  start_err = 1'b1;
        end
      end
      ST_KEY_LOAD: begin
        key_ready_o = 1'b1;
        adv         = key_valid_i;
        if (key_valid_i && ((KCNT_W'(wcnt_q) + KCNT_W'(1)) == key_len_q))
          state_d = ST_IKEY;
      end
      ST_IKEY, ST_OKEY: begin
        core_valid_o = 1'b1;
        core_data_o  = pad_word;
        core_start_o = entry_q;
        adv          = core_ready_i;
        if (core_ready_i && (wcnt_q == BLK_LAST))
          state_d = (state_q == ST_IKEY) ? ST_MSG : ST_ODIG;
      end
      ST_MSG: begin
        core_data_o  = data_i;
        core_valid_o = data_valid_i;
        core_last_o  = data_last_i;
        data_ready_o = core_ready_i;
        core_start_o = entry_q && !mode_q;
        if (data_valid_i && core_ready_i && data_last_i)
          state_d = mode_q ? ST_WAIT_I : ST_WAIT_O;
      end
      ST_WAIT_I: begin
        if (core_done_i) state_d = ST_OKEY;
      end
      ST_ODIG: begin
        // Captured digest shifts out MS word first.
        core_valid_o = 1'b1;
        core_data_o  = dig_q[DIG_W-1 -: WORD_W];
        core_last_o  = (wcnt_q == DIG_LAST);
        adv          = core_ready_i;
        if (core_ready_i && (wcnt_q == DIG_LAST)) state_d = ST_WAIT_O;
      end
      ST_WAIT_O: begin
        if (core_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (aborting) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      key_len_q    <= '0;
      wcnt_q       <= '0;
      entry_q      <= 1'b0;
      dig_q        <= '0;
      hash_q       <= '0;
      key_loaded_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) key_q[i] <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      done_q  <= 1'b0;
      err_q   <= start_err;

      if (state_d != state_q) wcnt_q <= '0;
      else if (adv)           wcnt_q <= wcnt_q + CNT_W'(1);

      if (state_q == ST_IDLE && start_i) begin
        mode_q    <= mode_i;
        key_len_q <= key_words_i;
      end

      // A fresh key load wipes the old key so short keys are zero filled.
      if (state_q == ST_IDLE && state_d == ST_KEY_LOAD) begin
        key_loaded_q <= 1'b0;
        for (int i = 0; i < BLOCK_WORDS; i++) key_q[i] <= '0;
      end

      if (key_acc) begin
        key_q[wcnt_q] <= key_i;
        if (state_d == ST_IKEY) key_loaded_q <= 1'b1;
      end

      if (state_q == ST_WAIT_I && state_d == ST_OKEY) dig_q <= core_digest_i;
      if (state_q == ST_ODIG && core_ready_i && !abort_i) dig_q <= dig_q << WORD_W;

      if (state_q == ST_WAIT_O && core_done_i && !abort_i) begin
        hash_q <= core_digest_i;
        done_q <= 1'b1;
      end
    end
  end

  assign hash_o       = hash_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign key_loaded_o = key_loaded_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lw_hmac_seq.sv
// tb/tb_lw_hmac_seq.sv - randomized bench for lw_hmac_seq with SHA-256 / 64-bit core models
module tb_lw_hmac_seq;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] RFC_HMAC = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, mode = 1'b0, reuse = 1'b0, sel = 1'b0, bp = 1'b0;
  logic         key_valid = 1'b0, data_valid = 1'b0, data_last = 1'b0, abort = 1'b0;
  logic [4:0]   key_words = '0;
  logic [63:0]  key = '0, data = '0;
  logic         core_ready = 1'b0, core_done = 1'b0;
  logic [511:0] core_digest = '0;

  logic a_key_ready, a_data_ready, a_cstart, a_cvalid, a_clast, a_cabort, a_done, a_busy, a_kl, a_err;
  logic b_key_ready, b_data_ready, b_cstart, b_cvalid, b_clast, b_cabort, b_done, b_busy, b_kl, b_err;
  logic [31:0]  a_cdata;
  logic [63:0]  b_cdata;
  logic [255:0] a_hash;
  logic [511:0] b_hash;

  lw_hmac_seq #(.WORD_W(32), .BLOCK_WORDS(16), .DIGEST_WORDS(8)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .mode_i(mode), .reuse_key_i(reuse),
    .key_words_i(key_words), .key_i(key[31:0]), .key_valid_i(key_valid & ~sel), .key_ready_o(a_key_ready),
    .data_i(data[31:0]), .data_valid_i(data_valid & ~sel), .data_last_i(data_last), .data_ready_o(a_data_ready),
    .abort_i(abort & ~sel), .core_start_o(a_cstart), .core_data_o(a_cdata), .core_valid_o(a_cvalid),
    .core_last_o(a_clast), .core_ready_i(core_ready), .core_abort_o(a_cabort), .core_done_i(core_done & ~sel),
    .core_digest_i(core_digest[255:0]), .hash_o(a_hash), .done_o(a_done), .busy_o(a_busy),
    .key_loaded_o(a_kl), .err_o(a_err));

  lw_hmac_seq #(.WORD_W(64), .BLOCK_WORDS(16), .DIGEST_WORDS(8)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .mode_i(mode), .reuse_key_i(reuse),
    .key_words_i(key_words), .key_i(key), .key_valid_i(key_valid & sel), .key_ready_o(b_key_ready),
    .data_i(data), .data_valid_i(data_valid & sel), .data_last_i(data_last), .data_ready_o(b_data_ready),
    .abort_i(abort & sel), .core_start_o(b_cstart), .core_data_o(b_cdata), .core_valid_o(b_cvalid),
    .core_last_o(b_clast), .core_ready_i(core_ready), .core_abort_o(b_cabort), .core_done_i(core_done & sel),
    .core_digest_i(core_digest), .hash_o(b_hash), .done_o(b_done), .busy_o(b_busy),
    .key_loaded_o(b_kl), .err_o(b_err));

  logic         c_start, c_valid, c_last, c_abort, done_w, busy_w, kl_w, err_w, key_ready_w, data_ready_w;
  logic [63:0]  c_data;
  logic [511:0] hash_w;
  assign c_start      = sel ? b_cstart : a_cstart;
  assign c_valid      = sel ? b_cvalid : a_cvalid;
  assign c_last       = sel ? b_clast : a_clast;
  assign c_abort      = sel ? b_cabort : a_cabort;
  assign c_data       = sel ? b_cdata : {32'h0, a_cdata};
  assign done_w       = sel ? b_done : a_done;
  assign busy_w       = sel ? b_busy : a_busy;
  assign kl_w         = sel ? b_kl : a_kl;
  assign err_w        = sel ? b_err : a_err;
  assign key_ready_w  = sel ? b_key_ready : a_key_ready;
  assign data_ready_w = sel ? b_data_ready : a_data_ready;
  assign hash_w       = sel ? b_hash : {256'h0, a_hash};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [63:0] m[$]);
    logic [31:0] p[$];
    logic [31:0] w[64];
    logic [31:0] h[8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    int n;
    n = m.size();
    foreach (m[i]) p.push_back(m[i][31:0]);
    p.push_back(32'h80000000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(n * 32));
    h = H256;
    for (int blk = 0; blk < p.size() / 16; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = p[blk*16 + t];
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
        t1 = hh + s1 + ((e & f) ^ (~e & g)) + K256[t] + w[t];
        s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
        t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // Stand-in 512-bit digest for the 64-bit core; only order/content sensitivity matters here.
  function automatic logic [511:0] toy512(input logic [63:0] m[$]);
    logic [511:0] r;
    logic [63:0] h;
    for (int j = 0; j < 8; j++) begin
      h = 64'hcbf29ce484222325 ^ 64'(j);
      foreach (m[i]) h = (h ^ m[i]) * 64'h100000001b3;
      h ^= 64'(m.size());
      r[511 - 64*j -: 64] = h;
    end
    return r;
  endfunction

  function automatic logic [511:0] hash_ref(input logic s, input logic [63:0] m[$]);
    return s ? toy512(m) : {256'h0, sha256(m)};
  endfunction

  function automatic logic [511:0] hmac_ref(input logic s, input logic [63:0] k[$], input logic [63:0] m[$]);
    logic [63:0] kb[16];
    logic [63:0] inner[$], outer[$];
    logic [63:0] ip, op;
    logic [511:0] d;
    ip = s ? {8{8'h36}} : 64'h36363636;
    op = s ? {8{8'h5c}} : 64'h5c5c5c5c;
    for (int i = 0; i < 16; i++) kb[i] = (i < k.size()) ? k[i] : 64'h0;
    for (int i = 0; i < 16; i++) inner.push_back(kb[i] ^ ip);
    foreach (m[i]) inner.push_back(m[i]);
    d = hash_ref(s, inner);
    for (int i = 0; i < 16; i++) outer.push_back(kb[i] ^ op);
    for (int j = 0; j < 8; j++) outer.push_back(s ? d[511 - 64*j -: 64] : {32'h0, d[255 - 32*j -: 32]});
    return hash_ref(s, outer);
  endfunction

  logic [63:0]  cbuf[$], q_prev[$], q_last[$];
  int           nstart = 0, pend = 0;
  logic [511:0] pdig = '0;

  always @(posedge clk) begin
    core_done <= 1'b0;
    core_ready <= bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rst || c_abort) begin
      cbuf.delete();
      pend <= 0;
    end else begin
      if (pend == 1) begin
        core_done   <= 1'b1;
        core_digest <= pdig;
      end
      if (pend > 0) pend <= pend - 1;
      if (c_start) begin
        cbuf.delete();
        nstart <= nstart + 1;
      end
      if (c_valid && core_ready) begin
        cbuf.push_back(c_data);
        if (c_last) begin
          q_prev = q_last;
          q_last = cbuf;
          pdig <= hash_ref(sel, cbuf);
          pend <= $urandom_range(1, 4);
        end
      end
    end
  end

  int n_done = 0, n_errp = 0, n_kr = 0, n_cs = 0;
  always @(posedge clk) begin
    if (done_w)      n_done <= n_done + 1;
    if (err_w)       n_errp <= n_errp + 1;
    if (key_ready_w) n_kr   <= n_kr + 1;
    if (c_start)     n_cs   <= n_cs + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic s, input logic md, input logic ru, input int nk);
    @(negedge clk);
    sel = s; mode = md; reuse = ru; key_words = 5'(nk); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_words(input logic is_key, input logic [63:0] q[$], input logic last_flag);
    int i, guard;
    logic acc;
    i = 0; guard = 0;
    while (i < q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (is_key) begin
        key = q[i];
        key_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        data = q[i];
        data_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        data_last = last_flag && (i == q.size() - 1);
      end
      #1;
      acc = is_key ? (key_valid && key_ready_w) : (data_valid && data_ready_w);
      @(posedge clk);
      if (acc) i++;
    end
    #1;
    key_valid = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    check_eq(is_key ? "key_words_taken" : "msg_words_taken", i, q.size());
  endtask

  task automatic wait_done(output logic got);
    int g;
    got = 1'b0; g = 0;
    while (!got && g < 3000) begin
      @(negedge clk);
      if (done_w) got = 1'b1;
      g++;
    end
  endtask

  task automatic run_op(input logic s, input logic md, input logic ru, input logic [63:0] k[$],
                        input logic [63:0] m[$], input string tag);
    logic [511:0] exp;
    logic got;
    int d0, c0;
    exp = md ? hmac_ref(s, k, m) : hash_ref(s, m);
    d0 = n_done; c0 = n_cs;
    do_start(s, md, ru, k.size());
    if (md && !ru) send_words(1'b1, k, 1'b0);
    send_words(1'b0, m, 1'b1);
    wait_done(got);
    check_eq({tag, "_done_seen"}, got, 1);
    check_eq({tag, "_hash"}, hash_w, exp);
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_done_cycles"}, n_done - d0, 1);
    check_eq({tag, "_core_starts"}, n_cs - c0, md ? 2 : 1);
  endtask

  function automatic logic [63:0] rword(input logic s);
    return s ? {$urandom, $urandom} : {32'h0, $urandom};
  endfunction

  logic [63:0] jefe[$], msg28[$], nokey[$], k16[$], rmsg[$], kcur[$], two[$];
  logic [511:0] h0;
  int d0, e0, c0, ns0, g;

  initial begin
    jefe  = '{64'h4a656665};
    msg28 = '{64'h77686174, 64'h20646f20, 64'h79612077, 64'h616e7420, 64'h666f7220, 64'h6e6f7468, 64'h696e673f};

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {a_busy, b_busy}, 0);
    check_eq("rst_pulses", {a_done, b_done, a_err, b_err, a_cstart, b_cstart}, 0);
    check_eq("rst_key_loaded", {a_kl, b_kl}, 0);
    check_eq("rst_ready_valid", {a_key_ready, b_key_ready, a_data_ready, b_data_ready, a_cvalid, b_cvalid}, 0);
    check_eq("rst_hash", {a_hash, b_hash}, 0);
    rst = 1'b0;

    run_op(1'b0, 1'b1, 1'b0, jefe, msg28, "rfc_hmac");
    check_eq("rfc_hmac_vector", hash_w, {256'h0, RFC_HMAC});
    check_eq("rfc_ikey0", q_prev[0], 64'h7c535053);
    check_eq("rfc_ikey1", q_prev[1], 64'h36363636);
    check_eq("rfc_okey0", q_last[0], 64'h16393a39);
    check_eq("rfc_okey15", q_last[15], 64'h5c5c5c5c);
    check_eq("rfc_stream_lens", {q_prev.size(), q_last.size()}, {32'd23, 32'd24});
    check_eq("rfc_key_loaded", kl_w, 1);

    c0 = n_kr;
    run_op(1'b0, 1'b1, 1'b1, jefe, msg28, "reuse");
    check_eq("reuse_vector", hash_w, {256'h0, RFC_HMAC});
    check_eq("reuse_no_key_ready", n_kr - c0, 0);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_eq("rst_clears_key", kl_w, 0);
    e0 = n_errp; c0 = n_cs;
    do_start(1'b0, 1'b1, 1'b1, 0);
    check_eq("reuse_nokey_err", {err_w, busy_w}, 2'b10);
    do_start(1'b0, 1'b1, 1'b0, 17);
    check_eq("klen17_err", {err_w, busy_w}, 2'b10);
    do_start(1'b0, 1'b1, 1'b0, 0);
    check_eq("klen0_err", {err_w, busy_w}, 2'b10);
    @(negedge clk);
    check_eq("err_pulse_count", n_errp - e0, 3);
    check_eq("err_no_core_start", n_cs - c0, 0);

    for (int i = 0; i < 16; i++) k16.push_back(rword(1'b0));
    for (int i = 0; i < 9; i++) rmsg.push_back(rword(1'b0));
    run_op(1'b0, 1'b1, 1'b0, k16, rmsg, "klen16");
    check_eq("klen16_ikey15", q_prev[15], k16[15] ^ 64'h36363636);

    run_op(1'b0, 1'b0, 1'b0, nokey, rmsg, "plain");
    check_eq("plain_stream_len", q_last.size(), rmsg.size());

    h0 = hash_w; d0 = n_done; ns0 = nstart; g = 0;
    do_start(1'b0, 1'b1, 1'b1, 0);
    send_words(1'b0, rmsg, 1'b1);
    while (!(nstart == ns0 + 2 && cbuf.size() == 19 && c_valid) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_eq("odig_word3_reached", cbuf.size(), 19);
    abort = 1'b1;
    #1 check_eq("odig_core_abort", c_abort, 1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_eq("odig_abort_idle", {busy_w, kl_w}, 2'b01);
    repeat (10) @(negedge clk);
    check_eq("odig_abort_no_done", n_done - d0, 0);
    check_eq("odig_abort_hash_kept", hash_w, h0);
    run_op(1'b0, 1'b1, 1'b1, k16, rmsg, "after_abort");

    two = '{k16[0], k16[1]};
    c0 = n_cs;
    do_start(1'b0, 1'b1, 1'b0, 5);
    send_words(1'b1, two, 1'b0);
    @(negedge clk);
    check_eq("kload_still_loading", key_ready_w, 1);
    abort = 1'b1;
    #1 check_eq("kload_core_abort", c_abort, 1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_eq("kload_abort_idle", {busy_w, kl_w}, 2'b00);
    check_eq("kload_abort_no_start", n_cs - c0, 0);

    bp = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int it = 0; it < 5; it++) begin
        logic md, ru;
        md = (it != 2);
        ru = (it == 4);
        if (!ru) begin
          kcur.delete();
          for (int i = 0; i < $urandom_range(1, 16); i++) kcur.push_back(rword(s[0]));
        end
        rmsg.delete();
        for (int i = 0; i < $urandom_range(1, 24); i++) rmsg.push_back(rword(s[0]));
        run_op(s[0], md, ru, kcur, rmsg, s[0] ? "rnd64" : "rnd32");
        check_eq("rnd_msg_stream", q_last.size(), md ? 24 : rmsg.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
    $finish;
  end

endmodule
